// File: rtl/commit_unit_pkg.sv
// Shared types and constants for the in-order commit stage.
package commit_unit_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } commit_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        mem;
    logic [31:0] addr;
    logic        halt;
    logic        ret;
  } commit_bundle_t;

  // Encoding the upstream decoder matches to raise wb_ebreak.
  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

endpackage

// File: rtl/commit_watchdog.sv
// No-progress watchdog: counts idle cycles and flags expiry at TIMEOUT-1.
module commit_watchdog #(
  parameter int TIMEOUT = 100000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic freeze,
  output logic expire
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] TERM = W'(TIMEOUT - 1);

  logic [W-1:0] count;
  logic         at_term;

  assign at_term = (count == TERM);
  assign expire  = enable & ~freeze & ~clear & at_term;

  // Saturates at the terminal value; the halt that follows freezes it anyway.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !freeze && !at_term) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/commit_unit.sv
// In-order retirement stage: registers one commit bundle per accepted
// instruction, detects ebreak / watchdog halts and counts retired instructions.
module commit_unit
  import commit_unit_pkg::*;
#(
  parameter int TIMEOUT = 100000,
  parameter int CNT_W   = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wb_valid,
  output logic             wb_ready,
  input  logic [31:0]      wb_pc,
  input  logic             wb_mem,
  input  logic [31:0]      wb_addr,
  input  logic             wb_ebreak,
  input  logic [31:0]      wb_a0,
  output logic             commit_commit,
  output logic [31:0]      commit_pc,
  output logic             commit_mem,
  output logic [31:0]      commit_addr,
  output logic             commit_halt,
  output logic             commit_ret,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  commit_state_t  state_q, state_d;
  commit_bundle_t bundle_q, bundle_d;
  logic           commit_q, commit_d;
  logic [31:0]    last_pc;
  logic           accept;
  logic           expire;

  assign wb_ready = (state_q == RUN);
  assign halted   = (state_q == HALTED);
  assign accept   = wb_valid & wb_ready;

  commit_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (accept),
    .enable (state_q == RUN),
    .freeze (state_q == HALTED),
    .expire (expire)
  );

  // An accept in the expiry cycle wins over the forced halt.
  always_comb begin
    state_d  = state_q;
    commit_d = 1'b0;
    bundle_d = '0;
    if (accept) begin
      commit_d      = 1'b1;
      bundle_d.pc   = wb_pc;
      bundle_d.mem  = wb_mem;
      bundle_d.addr = wb_mem ? wb_addr : 32'h0;
      bundle_d.halt = wb_ebreak;
      bundle_d.ret  = wb_ebreak && (wb_a0 == 32'h0);
      if (wb_ebreak) state_d = HALTED;
    end else if (expire) begin
      commit_d      = 1'b1;
      bundle_d.pc   = last_pc;
      bundle_d.halt = 1'b1;
      state_d       = HALTED;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= RUN;
      commit_q <= 1'b0;
      bundle_q <= '0;
      last_pc  <= '0;
      instret  <= '0;
    end else begin
      state_q  <= state_d;
      commit_q <= commit_d;
      bundle_q <= bundle_d;
      if (accept) begin
        instret <= instret + CNT_W'(1);
        last_pc <= wb_pc;
      end
    end
  end

  assign commit_commit = commit_q;
  assign commit_pc     = bundle_q.pc;
  assign commit_mem    = bundle_q.mem;
  assign commit_addr   = bundle_q.addr;
  assign commit_halt   = bundle_q.halt;
  assign commit_ret    = bundle_q.ret;

endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit with a short watchdog timeout.
module tb_commit_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_pc;
  logic        wb_mem;
  logic [31:0] wb_addr;
  logic        wb_ebreak;
  logic [31:0] wb_a0;
  logic        commit_commit;
  logic [31:0] commit_pc;
  logic        commit_mem;
  logic [31:0] commit_addr;
  logic        commit_halt;
  logic        commit_ret;
  logic        halted;
  logic [63:0] instret;

  int errors = 0;
  int checks = 0;

  commit_unit #(.TIMEOUT(8), .CNT_W(64)) dut (
    .clock         (clock),
    .reset         (reset),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .wb_pc         (wb_pc),
    .wb_mem        (wb_mem),
    .wb_addr       (wb_addr),
    .wb_ebreak     (wb_ebreak),
    .wb_a0         (wb_a0),
    .commit_commit (commit_commit),
    .commit_pc     (commit_pc),
    .commit_mem    (commit_mem),
    .commit_addr   (commit_addr),
    .commit_halt   (commit_halt),
    .commit_ret    (commit_ret),
    .halted        (halted),
    .instret       (instret)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid  = 1'b0;
    wb_pc     = 32'h0;
    wb_mem    = 1'b0;
    wb_addr   = 32'h0;
    wb_ebreak = 1'b0;
    wb_a0     = 32'h0;
  endtask

  task automatic drive(input logic [31:0] pc, input logic mem, input logic [31:0] addr,
                       input logic ebreak, input logic [31:0] a0);
    wb_valid  = 1'b1;
    wb_pc     = pc;
    wb_mem    = mem;
    wb_addr   = addr;
    wb_ebreak = ebreak;
    wb_a0     = a0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_bundle(input string tag, input logic c, input logic [31:0] pc,
                            input logic mem, input logic [31:0] addr,
                            input logic halt, input logic ret);
    chk({tag, ".commit"}, 64'(commit_commit), 64'(c));
    chk({tag, ".pc"},     64'(commit_pc),     64'(pc));
    chk({tag, ".mem"},    64'(commit_mem),    64'(mem));
    chk({tag, ".addr"},   64'(commit_addr),   64'(addr));
    chk({tag, ".halt"},   64'(commit_halt),   64'(halt));
    chk({tag, ".ret"},    64'(commit_ret),    64'(ret));
  endtask

  initial begin
    // reset state
    do_reset();
    chk_bundle("rst", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("rst.halted", 64'(halted), 64'd0);
    chk("rst.instret", instret, 64'd0);
    chk("rst.ready", 64'(wb_ready), 64'd1);

    // three back-to-back accepts, middle one a store
    drive(32'h8000_0000, 1'b0, 32'h0, 1'b0, 32'h5);
    tick();
    chk_bundle("b2b0", 1'b1, 32'h8000_0000, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(32'h8000_0004, 1'b1, 32'h8000_1000, 1'b0, 32'h0);
    tick();
    chk_bundle("b2b1", 1'b1, 32'h8000_0004, 1'b1, 32'h8000_1000, 1'b0, 1'b0);
    drive(32'h8000_0008, 1'b0, 32'hdead_beef, 1'b0, 32'h0);
    tick();
    chk_bundle("b2b2", 1'b1, 32'h8000_0008, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("b2b.instret", instret, 64'd3);

    // good ebreak, then wb_valid held high while halted
    drive(32'h8000_000c, 1'b0, 32'h0, 1'b1, 32'h0);
    tick();
    chk_bundle("ebk_good", 1'b1, 32'h8000_000c, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("ebk_good.halted", 64'(halted), 64'd1);
    chk("ebk_good.ready", 64'(wb_ready), 64'd0);
    chk("ebk_good.instret", instret, 64'd4);
    drive(32'h8000_0010, 1'b1, 32'h8000_2000, 1'b1, 32'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("halted.nopulse", 64'(commit_commit), 64'd0);
      chk("halted.nohalt", 64'(commit_halt), 64'd0);
    end
    chk("halted.instret", instret, 64'd4);
    chk("halted.level", 64'(halted), 64'd1);

    // bad ebreak
    do_reset();
    drive(32'h8000_000c, 1'b0, 32'h0, 1'b1, 32'h1);
    tick();
    chk_bundle("ebk_bad", 1'b1, 32'h8000_000c, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("ebk_bad.instret", instret, 64'd1);
    idle_inputs();
    tick();
    chk("ebk_bad.after", 64'(commit_commit), 64'd0);

    // timeout: pulse exactly 8 cycles after the commit cycle
    do_reset();
    drive(32'h8000_0010, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    idle_inputs();
    chk("to.commit0", 64'(commit_commit), 64'd1);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("to.quiet", 64'(commit_commit), 64'd0);
    end
    tick();
    chk_bundle("to.halt", 1'b1, 32'h8000_0010, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("to.instret", instret, 64'd1);
    chk("to.halted", 64'(halted), 64'd1);
    tick();
    chk("to.after", 64'(commit_commit), 64'd0);

    // accept in expiry cycle takes priority, watchdog restarts
    do_reset();
    drive(32'h8000_0010, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    idle_inputs();
    for (int i = 1; i < 8; i++) tick();
    drive(32'h8000_0014, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    idle_inputs();
    chk_bundle("exp_acc", 1'b1, 32'h8000_0014, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("exp_acc.instret", instret, 64'd2);
    chk("exp_acc.halted", 64'(halted), 64'd0);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("exp_acc.quiet", 64'(commit_commit), 64'd0);
    end
    tick();
    chk_bundle("exp_acc.to", 1'b1, 32'h8000_0014, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("exp_acc.to_instret", instret, 64'd2);

    // reset in the cycle after an ebreak accept
    do_reset();
    drive(32'h8000_000c, 1'b0, 32'h0, 1'b1, 32'h0);
    tick();
    idle_inputs();
    reset = 1'b1;
    tick();
    chk("rst_ebk.commit", 64'(commit_commit), 64'd0);
    chk("rst_ebk.halted", 64'(halted), 64'd0);
    chk("rst_ebk.instret", instret, 64'd0);
    chk("rst_ebk.ready", 64'(wb_ready), 64'd1);
    reset = 1'b0;

    // reset together with an ebreak accept: bundle discarded
    drive(32'h8000_000c, 1'b0, 32'h0, 1'b1, 32'h0);
    reset = 1'b1;
    tick();
    idle_inputs();
    reset = 1'b0;
    chk("rst_acc.commit", 64'(commit_commit), 64'd0);
    chk("rst_acc.halted", 64'(halted), 64'd0);
    chk("rst_acc.instret", instret, 64'd0);

    // reset in the watchdog expiry cycle
    do_reset();
    drive(32'h8000_0010, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    idle_inputs();
    for (int i = 1; i < 8; i++) tick();
    reset = 1'b1;
    tick();
    chk("rst_exp.commit", 64'(commit_commit), 64'd0);
    chk("rst_exp.halted", 64'(halted), 64'd0);
    chk("rst_exp.instret", instret, 64'd0);
    chk("rst_exp.ready", 64'(wb_ready), 64'd1);
    reset = 1'b0;
    tick();
    chk("rst_exp.after", 64'(commit_commit), 64'd0);
    chk("rst_exp.run", 64'(halted), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/commit_unit.md
Name: commit_unit

Overview:
- Final in-order retirement stage, sitting directly upstream of the simulation-exit/commit-trace sink.
- Accepts one written-back instruction per cycle over a valid/ready handshake and registers it into a one-cycle commit bundle (commit_*).
- Detects the ebreak halt condition and classifies the trap as good or bad from a0.
- Runs a no-progress watchdog that forces a bad halt when nothing retires for too long; maintains the retired-instruction counter.

Parameters:
- TIMEOUT, 100000, consecutive RUN cycles without an accepted instruction before a forced halt; must be >= 1.
- CNT_W, 64, width of instret.

Ports:
- clock, input, 1, sole clock.
- reset, input, 1, synchronous active-high reset.
- wb_valid, input, 1, writeback holds a retiring instruction.
- wb_ready, output, 1, unit accepts this cycle.
- wb_pc, input, 32, PC of the retiring instruction.
- wb_mem, input, 1, instruction is a load or store.
- wb_addr, input, 32, effective memory address; meaningful only when wb_mem=1.
- wb_ebreak, input, 1, instruction is ebreak.
- wb_a0, input, 32, value of x10 as seen by this instruction.
- commit_commit, output, 1, one-cycle pulse: bundle valid.
- commit_pc, output, 32, committed PC.
- commit_mem, output, 1, committed memory flag.
- commit_addr, output, 32, committed address (0 when commit_mem=0).
- commit_halt, output, 1, this commit ends simulation.
- commit_ret, output, 1, 1 = good trap (a0==0), 0 = bad trap or timeout.
- halted, output, 1, level: unit is in HALTED.
- instret, output, CNT_W, count of committed instructions, including the ebreak.

Behaviour:
- Reset (synchronous, wins over everything):
  - State goes to RUN.
  - All commit_* = 0, halted = 0, instret = 0, watchdog = 0, last_pc = 0.
  - Reset asserted mid-halt or mid-commit discards the pending bundle; no commit_commit pulse occurs in the cycle after reset.
- States: RUN, HALTED. There is no intermediate state.
- RUN:
  - wb_ready = 1 combinationally.
  - Accept fires when wb_valid & wb_ready.
  - On accept, the next cycle shows commit_commit = 1, commit_pc = wb_pc, commit_mem = wb_mem, commit_addr = wb_mem ? wb_addr : 0.
  - Also on accept: instret += 1 (wraps modulo 2^CNT_W), last_pc <= wb_pc, watchdog <= 0.
  - Latency is exactly 1 cycle from accept to commit_commit.
  - Back-to-back accepts produce back-to-back pulses.
- Ebreak:
  - An accept with wb_ebreak = 1 produces a commit with commit_halt = 1 and commit_ret = (wb_a0 == 0).
  - The state moves to HALTED on the same edge.
- Watchdog:
  - In RUN with no accept, watchdog += 1.
  - When watchdog == TIMEOUT-1 and no accept occurs, the next cycle shows one commit_commit pulse with commit_halt = 1, commit_ret = 0, commit_pc = last_pc, commit_mem = 0, commit_addr = 0.
  - instret is unchanged on a timeout; the state moves to HALTED.
  - An accept in the expiry cycle takes priority: it commits normally and the watchdog clears.
- HALTED:
  - wb_ready = 0 and halted = 1; wb_valid is ignored.
  - commit_commit stays 0 after the single halt pulse.
  - The watchdog is frozen, and instret holds its value.
  - Exit is by reset only.
- When commit_commit = 0, all other commit_* outputs are 0. They are not held from the previous commit.
- Invariant: exactly one commit_halt = 1 pulse per run.

Decomposition:
- Shared package holds:
  - the state enum (RUN, HALTED);
  - the commit bundle typedef {pc, mem, addr, halt, ret};
  - the constant EBREAK_INST = 32'h0010_0073, used by the decoder that drives wb_ebreak.
- One sub-module, commit_watchdog: a counter with TIMEOUT parameter and inputs clear/enable/freeze, output expire. Everything else stays inline.

Test Plan:
- Reset, then 3 back-to-back accepts (pc 0x80000000, 0x80000004, 0x80000008; the second is a store to 0x80001000) -> 3 consecutive pulses one cycle later with matching pc; commit_mem/addr = 1/0x80001000 only on the second; instret = 3.
- Accept ebreak at pc 0x8000000c with wb_a0 = 0 -> next cycle commit_halt = 1, commit_ret = 1; halted = 1; wb_ready = 0. Holding wb_valid high for 10 further cycles produces no further pulses and instret stays 4.
- Same ebreak with wb_a0 = 0x1 -> commit_halt = 1, commit_ret = 0.
- TIMEOUT = 8, one accept at pc 0x80000010, then idle -> halt pulse appears exactly 8 cycles after the accept's commit cycle, with pc 0x80000010, ret = 0, mem = 0; instret = 1.
- TIMEOUT = 8, wb_valid on the expiry cycle -> normal commit, no halt; the watchdog restarts from 0 and a timeout occurs 8 idle cycles later.
- Reset asserted in the cycle after an ebreak accept and in the watchdog-expiry cycle -> no commit_commit pulse; state RUN; instret = 0; wb_ready = 1.
